// File: rtl/pong_ctrl.sv
// Game-control FSM for the 18-LED Pong datapath: serve, rally hit/miss decisions,
// shift/timer strobes and packed-BCD scoring for both players.
module pong_ctrl #(
    parameter int unsigned BALL_W      = 18,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              CLRN,
    input  logic              BTN1,
    input  logic              BTN0,
    input  logic              TC,
    input  logic [BALL_W-1:0] BALL,
    input  logic              DIR_RAND,
    input  logic              GAMEOVER,
    output logic              LOAD,
    output logic              SHL,
    output logic              SHR,
    output logic              SET,
    output logic              MAX,
    output logic [7:0]        SCORE1,
    output logic [7:0]        SCORE0,
    output logic [2:0]        STATE
);

    localparam int unsigned SCORE_W = 8;

    typedef enum logic [2:0] {
        SERVE_WAIT = 3'd0,
        RALLY      = 3'd1,
        POINT      = 3'd2,
        OVER       = 3'd3
    } state_t;

    state_t               state, state_n;
    logic                 dir, dir_n;          // 1 = moving left, toward player 1
    logic                 pt_cnt, pt_cnt_n;
    logic [SCORE_W-1:0]   score1_n, score0_n;
    logic                 load_n, shl_n, shr_n, set_n, max_n;

    logic [SYNC_STAGES-1:0] sync1, sync0;
    logic                   prev1, prev0;
    logic                   lvl1, lvl0, press1, press0;
    logic                   ball_live, at_left, at_right, hit, at_end;

    // Packed-BCD increment, saturating at 99
    function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
        if (v == 8'h99)
            return v;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign lvl1   = sync1[SYNC_STAGES-1];
    assign lvl0   = sync0[SYNC_STAGES-1];
    assign press1 = lvl1 & ~prev1;
    assign press0 = lvl0 & ~prev0;

    assign ball_live = |BALL;
    assign at_left   = ball_live & BALL[BALL_W-1];
    assign at_right  = ball_live & BALL[0];
    assign hit       = (dir & at_left & press1) | (~dir & at_right & press0);
    assign at_end    = dir ? at_left : at_right;

    assign STATE = state;

    // State, score, strobe and button-synchronizer registers
    always_ff @(posedge CLK or negedge CLRN) begin
        if (!CLRN) begin
            state  <= SERVE_WAIT;
            dir    <= 1'b0;
            pt_cnt <= 1'b0;
            SCORE1 <= '0;
            SCORE0 <= '0;
            LOAD   <= 1'b0;
            SHL    <= 1'b0;
            SHR    <= 1'b0;
            SET    <= 1'b0;
            MAX    <= 1'b0;
            sync1  <= '0;
            sync0  <= '0;
            prev1  <= 1'b0;
            prev0  <= 1'b0;
        end else begin
            state  <= state_n;
            dir    <= dir_n;
            pt_cnt <= pt_cnt_n;
            SCORE1 <= score1_n;
            SCORE0 <= score0_n;
            LOAD   <= load_n;
            SHL    <= shl_n;
            SHR    <= shr_n;
            SET    <= set_n;
            MAX    <= max_n;
            sync1  <= {sync1[SYNC_STAGES-2:0], BTN1};
            sync0  <= {sync0[SYNC_STAGES-2:0], BTN0};
            prev1  <= lvl1;
            prev0  <= lvl0;
        end
    end

    // Next-state and strobe decisions
    always_comb begin
        state_n  = state;
        dir_n    = dir;
        pt_cnt_n = pt_cnt;
        score1_n = SCORE1;
        score0_n = SCORE0;
        load_n   = 1'b0;
        shl_n    = 1'b0;
        shr_n    = 1'b0;
        set_n    = 1'b0;
        max_n    = 1'b0;

        case (state)
            SERVE_WAIT: begin
                if (press1 || press0) begin
                    load_n  = 1'b1;
                    max_n   = 1'b1;
                    dir_n   = DIR_RAND;
                    state_n = RALLY;
                end
            end
            RALLY: begin
                if (hit) begin
                    dir_n = ~dir;
                    set_n = 1'b1;
                end
                if (TC) begin
                    // A same-cycle hit shifts in the freshly toggled direction
                    if (dir_n)
                        shl_n = 1'b1;
                    else
                        shr_n = 1'b1;
                    if (!hit && at_end) begin
                        if (dir)
                            score0_n = bcd_inc(SCORE0);
                        else
                            score1_n = bcd_inc(SCORE1);
                        pt_cnt_n = 1'b0;
                        state_n  = POINT;
                    end
                end
            end
            POINT: begin
                // Second cycle lets the win detector see the updated score
                pt_cnt_n = 1'b1;
                if (pt_cnt) begin
                    pt_cnt_n = 1'b0;
                    state_n  = GAMEOVER ? OVER : SERVE_WAIT;
                end
            end
            OVER: begin
                if (lvl1 && lvl0) begin
                    score1_n = '0;
                    score0_n = '0;
                    max_n    = 1'b1;
                    state_n  = SERVE_WAIT;
                end
            end
            default: state_n = SERVE_WAIT;
        endcase
    end

endmodule

// File: tb/tb_pong_ctrl.sv
// Directed bench for pong_ctrl: serve, hit, miss, BCD scoring, game-over restart
// and asynchronous reset. Strobe vectors are ordered {LOAD,SHL,SHR,SET,MAX}.
module tb_pong_ctrl;

    logic        CLK = 1'b0;
    logic        CLRN;
    logic        BTN1, BTN0, TC, DIR_RAND, GAMEOVER;
    logic [17:0] BALL;
    logic        LOAD, SHL, SHR, SET, MAX;
    logic [7:0]  SCORE1, SCORE0;
    logic [2:0]  STATE;
    logic [4:0]  strb;

    int checks = 0;
    int errors = 0;

    pong_ctrl dut (
        .CLK(CLK), .CLRN(CLRN), .BTN1(BTN1), .BTN0(BTN0), .TC(TC),
        .BALL(BALL), .DIR_RAND(DIR_RAND), .GAMEOVER(GAMEOVER),
        .LOAD(LOAD), .SHL(SHL), .SHR(SHR), .SET(SET), .MAX(MAX),
        .SCORE1(SCORE1), .SCORE0(SCORE0), .STATE(STATE)
    );

    always #5 CLK = ~CLK;
    assign strb = {LOAD, SHL, SHR, SET, MAX};

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Press and release; returns strobes on the decision-output cycle and the one after
    task automatic press(input logic b1, input logic b0, output logic [4:0] at_c, output logic [4:0] at_d);
        BTN1 = b1; BTN0 = b0;
        tick(); tick(); tick();
        at_c = strb;
        BTN1 = 1'b0; BTN0 = 1'b0;
        tick();
        at_d = strb;
        tick(); tick();
    endtask

    task automatic pulse_tc(output logic [4:0] s);
        TC = 1'b1;
        tick();
        s  = strb;
        TC = 1'b0;
    endtask

    // Serve toward player 0 then let the ball escape at the right end
    task automatic miss_right();
        logic [4:0] c, d;
        DIR_RAND = 1'b0;
        press(1'b0, 1'b1, c, d);
        BALL = 18'h00001;
        pulse_tc(c);
        BALL = 18'h0;
        tick(); tick(); tick();
    endtask

    task automatic test_reset();
        CLRN = 1'b0; BTN1 = 0; BTN0 = 0; TC = 0; DIR_RAND = 0; GAMEOVER = 0; BALL = '0;
        tick(); tick(); tick();
        CLRN = 1'b1;
        tick();
        checks++; if (strb !== 5'b00000) begin errors++; $display("FAIL reset_strobes: got %b expected 00000", strb); end
        checks++; if (SCORE1 !== 8'h00 || SCORE0 !== 8'h00) begin errors++; $display("FAIL reset_scores: got %h/%h expected 00/00", SCORE1, SCORE0); end
        checks++; if (STATE !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", STATE); end
    endtask

    task automatic test_serve();
        logic [4:0] s;
        DIR_RAND = 1'b1;
        BTN0 = 1'b1;
        tick(); tick();
        checks++; if (strb !== 5'b00000) begin errors++; $display("FAIL serve_early: got %b expected 00000", strb); end
        tick();
        checks++; if (strb !== 5'b10001) begin errors++; $display("FAIL serve_load_max: got %b expected 10001", strb); end
        checks++; if (STATE !== 3'd1) begin errors++; $display("FAIL serve_state: got %0d expected 1", STATE); end
        BTN0 = 1'b0;
        tick();
        checks++; if (strb !== 5'b00000) begin errors++; $display("FAIL serve_one_cycle: got %b expected 00000", strb); end
        tick(); tick();
        BALL = 18'h00100;
        pulse_tc(s);
        checks++; if (s !== 5'b01000) begin errors++; $display("FAIL serve_first_shift: got %b expected 01000", s); end
    endtask

    task automatic test_hit();
        logic [4:0] c, d, s;
        BALL = 18'h00100;
        press(1'b1, 1'b0, c, d);
        checks++; if (c !== 5'b00000) begin errors++; $display("FAIL reject_press: got %b expected 00000", c); end
        BALL = 18'h20000;
        press(1'b1, 1'b0, c, d);
        checks++; if (c !== 5'b00010) begin errors++; $display("FAIL hit_set: got %b expected 00010", c); end
        checks++; if (d !== 5'b00000) begin errors++; $display("FAIL hit_set_once: got %b expected 00000", d); end
        BALL = 18'h10000;
        pulse_tc(s);
        checks++; if (s !== 5'b00100) begin errors++; $display("FAIL hit_reverse: got %b expected 00100", s); end
        checks++; if (SCORE1 !== 8'h00 || SCORE0 !== 8'h00) begin errors++; $display("FAIL hit_scores: got %h/%h expected 00/00", SCORE1, SCORE0); end
    endtask

    task automatic test_hit_tc();
        BALL = 18'h00001;
        BTN0 = 1'b1;
        tick(); tick();
        TC = 1'b1;
        tick();
        checks++; if (strb !== 5'b01010) begin errors++; $display("FAIL hit_with_tc: got %b expected 01010", strb); end
        checks++; if (STATE !== 3'd1 || SCORE1 !== 8'h00 || SCORE0 !== 8'h00) begin errors++; $display("FAIL hit_with_tc_score: got state %0d scores %h/%h expected 1 00/00", STATE, SCORE1, SCORE0); end
        TC = 1'b0; BTN0 = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_miss();
        logic [4:0] s;
        BALL = 18'h20000;
        pulse_tc(s);
        checks++; if (s !== 5'b01000) begin errors++; $display("FAIL miss_shift: got %b expected 01000", s); end
        checks++; if (SCORE0 !== 8'h01 || SCORE1 !== 8'h00) begin errors++; $display("FAIL miss_score: got %h/%h expected 00/01", SCORE1, SCORE0); end
        checks++; if (STATE !== 3'd2) begin errors++; $display("FAIL miss_point1: got %0d expected 2", STATE); end
        BALL = 18'h0;
        tick();
        checks++; if (STATE !== 3'd2) begin errors++; $display("FAIL miss_point2: got %0d expected 2", STATE); end
        tick();
        checks++; if (STATE !== 3'd0) begin errors++; $display("FAIL miss_to_serve: got %0d expected 0", STATE); end
    endtask

    task automatic test_scores();
        for (int i = 0; i < 9; i++) miss_right();
        checks++; if (SCORE1 !== 8'h09) begin errors++; $display("FAIL score_09: got %h expected 09", SCORE1); end
        miss_right();
        checks++; if (SCORE1 !== 8'h10) begin errors++; $display("FAIL score_carry: got %h expected 10", SCORE1); end
        miss_right();
        checks++; if (SCORE1 !== 8'h11) begin errors++; $display("FAIL score_11: got %h expected 11", SCORE1); end
        GAMEOVER = 1'b1;
        miss_right();
        checks++; if (SCORE1 !== 8'h12 || SCORE0 !== 8'h01) begin errors++; $display("FAIL score_final: got %h/%h expected 12/01", SCORE1, SCORE0); end
        checks++; if (STATE !== 3'd3) begin errors++; $display("FAIL gameover_state: got %0d expected 3", STATE); end
    endtask

    task automatic test_over();
        logic [4:0] c, d;
        press(1'b1, 1'b0, c, d);
        checks++; if (c !== 5'b00000 || d !== 5'b00000) begin errors++; $display("FAIL over_single_press: got %b %b expected 00000 00000", c, d); end
        checks++; if (STATE !== 3'd3 || SCORE1 !== 8'h12 || SCORE0 !== 8'h01) begin errors++; $display("FAIL over_frozen: got state %0d scores %h/%h expected 3 12/01", STATE, SCORE1, SCORE0); end
        BTN1 = 1'b1; BTN0 = 1'b1;
        tick(); tick();
        GAMEOVER = 1'b0;
        tick();
        checks++; if (strb !== 5'b00001) begin errors++; $display("FAIL restart_max: got %b expected 00001", strb); end
        checks++; if (STATE !== 3'd0 || SCORE1 !== 8'h00 || SCORE0 !== 8'h00) begin errors++; $display("FAIL restart_clear: got state %0d scores %h/%h expected 0 00/00", STATE, SCORE1, SCORE0); end
        tick();
        checks++; if (strb !== 5'b00000 || STATE !== 3'd0) begin errors++; $display("FAIL restart_held: got %b state %0d expected 00000 state 0", strb, STATE); end
        BTN1 = 1'b0; BTN0 = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_reset_mid();
        logic [4:0] c, d, s;
        DIR_RAND = 1'b1;
        press(1'b0, 1'b1, c, d);
        BALL = 18'h20000;
        pulse_tc(s);
        BALL = 18'h0;
        tick(); tick(); tick();
        checks++; if (SCORE0 !== 8'h01) begin errors++; $display("FAIL premid_score: got %h expected 01", SCORE0); end
        press(1'b0, 1'b1, c, d);
        BALL = 18'h00100;
        TC = 1'b1;
        tick();
        checks++; if (strb !== 5'b01000) begin errors++; $display("FAIL premid_shift: got %b expected 01000", strb); end
        CLRN = 1'b0;
        #1;
        checks++; if (strb !== 5'b00000) begin errors++; $display("FAIL midreset_strobes: got %b expected 00000", strb); end
        checks++; if (STATE !== 3'd0 || SCORE1 !== 8'h00 || SCORE0 !== 8'h00) begin errors++; $display("FAIL midreset_regs: got state %0d scores %h/%h expected 0 00/00", STATE, SCORE1, SCORE0); end
        TC = 1'b0;
        tick();
        CLRN = 1'b1;
        tick();
        checks++; if (strb !== 5'b00000 || STATE !== 3'd0) begin errors++; $display("FAIL postreset: got %b state %0d expected 00000 state 0", strb, STATE); end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_hit();
        test_hit_tc();
        test_miss();
        test_scores();
        test_over();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pong_ctrl.md
Name: pong_ctrl

Overview:
- Game-control FSM for the 18-LED Pong datapath.
- Sits upstream of the ball shift register and the variable timer. Drives their LOAD/SHL/SHR and SET/MAX strobes from the ball position, the timer terminal count and the player buttons.
- Keeps both BCD scores, which feed the win detector. Consumes the detector's GAMEOVER.

Parameters:
- BALL_W, 18: ball shift-register width. Player 1 sits at bit BALL_W-1 (left end); player 0 sits at bit 0 (right end).
- SYNC_STAGES, 2: flip-flop stages in each button synchronizer. Minimum 2.

Ports:
- CLK  in  1  system clock.
- CLRN  in  1  asynchronous, active-low reset.
- BTN1  in  1  player-1 (left) button, asynchronous, active-high.
- BTN0  in  1  player-0 (right) button, asynchronous, active-high.
- TC  in  1  timer terminal count, one-cycle pulse.
- BALL  in  BALL_W  current ball shift-register contents.
- DIR_RAND  in  1  random serve direction; 1 = serve left (toward player 1).
- GAMEOVER  in  1  from win detector.
- LOAD  out  1  one-cycle strobe: load serve pattern.
- SHL  out  1  one-cycle strobe: shift toward bit BALL_W-1.
- SHR  out  1  one-cycle strobe: shift toward bit 0.
- SET  out  1  one-cycle strobe: timer speed-up.
- MAX  out  1  one-cycle strobe: timer back to slowest.
- SCORE1  out  8  player-1 score, packed BCD.
- SCORE0  out  8  player-0 score, packed BCD.
- STATE  out  3  state encoding, for debug.

Behaviour:
- Reset (CLRN=0): takes effect immediately, at any point including mid-rally.
  - All strobes 0; SCORE1 = SCORE0 = 8'h00.
  - State = SERVE_WAIT; dir register = 0; synchronizers and edge detectors cleared.
- Buttons: each passes through a SYNC_STAGES synchronizer, then a rising-edge detector. A press is one cycle of PRESS1 or PRESS0. Held buttons produce no further presses.
- Registered outputs: all strobes are registered. A decision taken in cycle N appears on the outputs in cycle N+1 for exactly one cycle.
- Left end: BALL[BALL_W-1]=1. Right end: BALL[0]=1.
- SERVE_WAIT:
  - On PRESS1 or PRESS0: strobe LOAD and MAX; latch dir = DIR_RAND; go to RALLY.
  - TC is ignored in this state.
- RALLY, hit:
  - Condition: dir=left, left end, PRESS1; or dir=right, right end, PRESS0.
  - Action: toggle dir; strobe SET.
- RALLY, press rejected: a press while the ball is not in that player's end cell, or while the ball is moving away from that player, is ignored. No strobe, no penalty.
- RALLY, TC without a miss: strobe SHL if dir=left, SHR if dir=right.
- RALLY, hit and TC in the same cycle: the hit wins.
  - dir is toggled first, and the shift uses the new direction.
  - SET and the shift strobe are asserted together.
- RALLY, miss:
  - Condition: TC while dir=left with the ball at the left end, or dir=right with the ball at the right end, and no hit in that cycle.
  - Action: strobe the shift in the current dir, so the ball leaves the array and BALL becomes 0.
  - Increment the opponent's score (left miss scores SCORE0; right miss scores SCORE1). Go to POINT.
- Score arithmetic: packed-BCD increment. Low digit 9 → 0 with carry into the high digit (8'h09 → 8'h10, 8'h19 → 8'h20). Saturates at 8'h99.
- POINT:
  - Lasts exactly 2 cycles, so GAMEOVER reflects the new score.
  - Then GAMEOVER=1 → OVER; otherwise → SERVE_WAIT.
  - Presses and TC are ignored.
- OVER:
  - Scores frozen; all strobes 0; single presses ignored.
  - Both synchronized button levels high in the same cycle: clear both scores, strobe MAX, go to SERVE_WAIT.
- State encoding: SERVE_WAIT=0, RALLY=1, POINT=2, OVER=3.
- Strobe exclusivity: at most one of LOAD/SHL/SHR is asserted in any cycle.

Test Plan:
- Reset, then PRESS0 with DIR_RAND=1 -> two cycles after the synchronized edge, LOAD=1 and MAX=1 for one cycle. STATE=1. The next TC gives SHL=1.
- BALL=18'h20000, dir=left, PRESS1 -> SET pulses once. The next TC gives SHR=1, not SHL. Scores unchanged.
- BALL=18'h20000, dir=left, TC with no press -> SHL=1, SCORE0 00→01. POINT lasts 2 cycles, then STATE=0.
- Press coincident with TC at BALL=18'h00001, dir=right -> SET=1 and SHL=1 in the same cycle. No score change.
- SCORE1=8'h09, player 0 misses -> SCORE1=8'h10. Preload 8'h11 with GAMEOVER driven high on the next miss -> STATE=3. Then single presses are ignored. Both buttons held -> scores 00, MAX pulse, STATE=0.
- CLRN pulsed low mid-rally, with a strobe pending -> all outputs 0 immediately. Scores 00; STATE=0.
